regfile_scoreboard: RTL

//  Parametrised integer register file, 2 async read ports / 1 sync write port, with per-register busy scoreboard.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file and its busy scoreboard.
// Configuration macro: RF_WB_BYPASS_EN (same-cycle writeback forwarding to ID).
package rf_pkg;

   localparam int XLEN_DEFAULT  = 64;
   localparam int NREGS_DEFAULT = 32;

   // Address width for a register file of nregs entries (at least one bit).
   function automatic int rf_aw(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

   localparam int AW_DEFAULT = rf_aw(NREGS_DEFAULT);

   typedef logic [AW_DEFAULT-1:0] reg_addr_t;

   // x0 is hard-wired to zero and can never be busy.
   localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register plus a registered
// popcount. Priority per register: flush > set (new producer) > clear (retire).
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   parameter int AW    = rf_aw(NREGS)
)(
   input  logic             clk,
   input  logic             srst,
   input  logic             set_en_i,
   input  logic [AW-1:0]    set_addr_i,
   input  logic             clr_en_i,
   input  logic [AW-1:0]    clr_addr_i,
   input  logic             flush_i,
   output logic [NREGS-1:0] busy_o,
   output logic [AW:0]      busy_count_o
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      count_q, count_d;

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      // Next busy state of register gi; x0 stays clear whatever is requested.
      always_comb begin
         busy_d[gi] = busy_q[gi];
         if (clr_en_i && clr_addr_i == AW'(gi)) busy_d[gi] = 1'b0;
         if (set_en_i && set_addr_i == AW'(gi)) busy_d[gi] = 1'b1;
         if (flush_i || gi == ZERO_REG)         busy_d[gi] = 1'b0;
      end
   end

   // Popcount of the next busy vector so the count lands on the same edge.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         count_d = count_d + (AW+1)'(busy_d[i]);
      end
   end

   // Busy vector and count registers.
   always_ff @(posedge clk) begin
      if (srst) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_o       = busy_q;
   assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file (2 async read ports, 1 sync write port) with a busy
// scoreboard that raises STALL when a used source has an in-flight producer.
// Configuration macro: RF_WB_BYPASS_EN -- when defined, a writeback in the
// same cycle is forwarded to the read ports and counts as already retired
// for STALL; when undefined, reads see only stored values.
module regfile_scoreboard
   import rf_pkg::*;
#(
   parameter int   XLEN  = XLEN_DEFAULT,
   parameter int   NREGS = NREGS_DEFAULT,
   localparam int  AW    = rf_aw(NREGS)
)(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            WE,
   input  logic [AW-1:0]   WR_ADDR,
   input  logic [XLEN-1:0] WR_DATA,
   input  logic [AW-1:0]   RD_ADDR1,
   input  logic [AW-1:0]   RD_ADDR2,
   input  logic            RD_USE1,
   input  logic            RD_USE2,
   output logic [XLEN-1:0] RD_DATA1,
   output logic [XLEN-1:0] RD_DATA2,
   input  logic            ISSUE_VALID,
   input  logic [AW-1:0]   ISSUE_RD,
   input  logic            FLUSH,
   output logic            STALL,
   output logic [AW:0]     BUSY_COUNT
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr_en;
   logic             issue_en;

   // Both the data write and the busy clear ignore x0.
   assign wr_en    = WE && (WR_ADDR != AW'(ZERO_REG));
   assign issue_en = ISSUE_VALID && (ISSUE_RD != AW'(ZERO_REG));

   // Register storage; x0 is only ever reset, never written.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[WR_ADDR] <= WR_DATA;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk          (CLK),
      .srst         (RESET),
      .set_en_i     (issue_en),
      .set_addr_i   (ISSUE_RD),
      .clr_en_i     (wr_en),
      .clr_addr_i   (WR_ADDR),
      .flush_i      (FLUSH),
      .busy_o       (busy),
      .busy_count_o (BUSY_COUNT)
   );

   // Read ports gathered into arrays so both share one generate body.
   logic [AW-1:0]   rd_addr [2];
   logic            rd_use  [2];
   logic [XLEN-1:0] rd_data [2];
   logic [1:0]      hazard;

   assign rd_addr[0] = RD_ADDR1;
   assign rd_addr[1] = RD_ADDR2;
   assign rd_use[0]  = RD_USE1;
   assign rd_use[1]  = RD_USE2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic src_zero;
      logic fwd_hit;
      logic src_busy;

      assign src_zero = (rd_addr[gi] == AW'(ZERO_REG));
      // wr_en already excludes x0, so a hit implies a nonzero source.
      assign fwd_hit  = wr_en && (WR_ADDR == rd_addr[gi]);

      // Read data mux: x0 reads zero, otherwise stored (or forwarded) value.
      always_comb begin
         rd_data[gi] = src_zero ? '0 : regs_q[rd_addr[gi]];
`ifdef RF_WB_BYPASS_EN
         if (fwd_hit) rd_data[gi] = WR_DATA;
`endif
      end

      // Source busy: a retiring producer counts as done only when forwarded.
      always_comb begin
         src_busy = busy[rd_addr[gi]];
`ifdef RF_WB_BYPASS_EN
         if (fwd_hit) src_busy = 1'b0;
`else
         if (fwd_hit && 1'b0) src_busy = 1'b0;
`endif
      end

      assign hazard[gi] = rd_use[gi] && !src_zero && src_busy;
   end

   assign RD_DATA1 = rd_data[0];
   assign RD_DATA2 = rd_data[1];
   assign STALL    = |hazard;

endmodule
